uart_decoder: RTL and testbench

- Receive-side counterpart of the MCU link's ASCII-hex UART transmitter.
- Deserialises the UART line, recognises framing symbols ':' (start), ';' (end), '#' (vsync) and '^' (interrupt).
- Reassembles hex-digit pairs into bytes for the MCU controller.
- Sits between the board UART RX pin and the MCU controller's command path.

---
 rtl/uart_decoder_pkg.sv | 43 ++++
 rtl/uart_decoder_if.sv | 21 ++
 rtl/uart_rx_core.sv | 95 +++++++++
 rtl/uart_decoder.sv | 99 +++++++++
 tb/tb_uart_decoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_decoder_pkg.sv
// Shared definitions for the MCU-link ASCII-hex UART receive path:
// framing symbols, state encodings and the hex digit decoder.
`timescale 1ns/1ps
package uart_decoder_pkg;

    // Framing symbols, common with the transmitter side of the link
    localparam logic [7:0] SYM_START = 8'h3A;  // ':'
    localparam logic [7:0] SYM_END   = 8'h3B;  // ';'
    localparam logic [7:0] SYM_VSYNC = 8'h23;  // '#'
    localparam logic [7:0] SYM_INTR  = 8'h5E;  // '^'
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        DEC_EMPTY,
        DEC_HALF
    } dec_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } nibble_t;

    // ASCII hex digit to nibble; valid is low for any non-hex character
    function automatic nibble_t hex_to_nibble(input logic [7:0] c);
        nibble_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (c >= 8'h30 && c <= 8'h39)      r.nibble = 4'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h46) r.nibble = 4'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h66) r.nibble = 4'(c - 8'h57);
        else                               r.valid  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/uart_decoder_if.sv
// Decoded-symbol bus from the UART decoder to the MCU controller.
`timescale 1ns/1ps
interface uart_decoder_if;
    logic [7:0] o_rx_data;
    logic       o_rx_data_valid;
    logic       o_rx_start;
    logic       o_rx_end;
    logic       o_rx_vsync;
    logic       o_rx_interrupt;
    logic       o_rx_error;

    modport master (
        output o_rx_data, o_rx_data_valid, o_rx_start, o_rx_end,
               o_rx_vsync, o_rx_interrupt, o_rx_error
    );

    modport slave (
        input  o_rx_data, o_rx_data_valid, o_rx_start, o_rx_end,
               o_rx_vsync, o_rx_interrupt, o_rx_error
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART line receiver: input synchroniser, mid-bit sampling timer and
// deserialiser producing a byte strobe or a framing-error strobe.
`timescale 1ns/1ps
module uart_rx_core
    import uart_decoder_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BOUD_RATE  = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BOUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;
    logic             w_fall;

    assign w_fall = r_rx_prev & ~r_rx_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) r_state <= RX_START;
                end
                // Re-check the line at mid start bit to reject glitches
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt        <= '0;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= ~r_rx_sync;
                        r_state      <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_decoder.sv
// ASCII-hex UART decoder: turns received characters into framing strobes
// and reassembled bytes for the MCU controller command path.
`timescale 1ns/1ps
module uart_decoder
    import uart_decoder_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BOUD_RATE  = 115200
) (
    input  logic           i_master_clk,
    input  logic           i_reset_n,
    input  logic           i_uart_rx,
    uart_decoder_if.master bus
);
    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    nibble_t    w_hex;

    dec_state_t r_state;
    logic [3:0] r_high;
    logic [7:0] r_rx_data;
    logic       r_rx_data_valid;
    logic       r_rx_start;
    logic       r_rx_end;
    logic       r_rx_vsync;
    logic       r_rx_interrupt;
    logic       r_rx_error;

    uart_rx_core #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BOUD_RATE  (BOUD_RATE)
    ) u_rx_core (
        .i_clk        (i_master_clk),
        .i_rst_n      (i_reset_n),
        .i_rx         (i_uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_hex = hex_to_nibble(w_byte);

    // Symbol / nibble-pair state machine; every strobe is a single cycle
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= DEC_EMPTY;
            r_high          <= 4'h0;
            r_rx_data       <= 8'h00;
            r_rx_data_valid <= 1'b0;
            r_rx_start      <= 1'b0;
            r_rx_end        <= 1'b0;
            r_rx_vsync      <= 1'b0;
            r_rx_interrupt  <= 1'b0;
            r_rx_error      <= 1'b0;
        end else begin
            r_rx_data_valid <= 1'b0;
            r_rx_start      <= 1'b0;
            r_rx_end        <= 1'b0;
            r_rx_vsync      <= 1'b0;
            r_rx_interrupt  <= 1'b0;
            r_rx_error      <= 1'b0;
            if (w_frame_err) begin
                r_rx_error <= 1'b1;
                r_state    <= DEC_EMPTY;
            end else if (w_byte_valid) begin
                case (w_byte)
                    SYM_START: begin r_rx_start     <= 1'b1; r_state <= DEC_EMPTY; end
                    SYM_END:   begin r_rx_end       <= 1'b1; r_state <= DEC_EMPTY; end
                    SYM_VSYNC: begin r_rx_vsync     <= 1'b1; r_state <= DEC_EMPTY; end
                    SYM_INTR:  begin r_rx_interrupt <= 1'b1; r_state <= DEC_EMPTY; end
                    CHR_CR, CHR_LF: ;  // line padding leaves a pending digit intact
                    default: begin
                        if (!w_hex.valid) begin
                            r_rx_error <= 1'b1;
                            r_state    <= DEC_EMPTY;
                        end else if (r_state == DEC_EMPTY) begin
                            r_high  <= w_hex.nibble;
                            r_state <= DEC_HALF;
                        end else begin
                            r_rx_data       <= {r_high, w_hex.nibble};
                            r_rx_data_valid <= 1'b1;
                            r_state         <= DEC_EMPTY;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.o_rx_data       = r_rx_data;
    assign bus.o_rx_data_valid = r_rx_data_valid;
    assign bus.o_rx_start      = r_rx_start;
    assign bus.o_rx_end        = r_rx_end;
    assign bus.o_rx_vsync      = r_rx_vsync;
    assign bus.o_rx_interrupt  = r_rx_interrupt;
    assign bus.o_rx_error      = r_rx_error;

endmodule

// File: tb/tb_uart_decoder.sv
// Self-checking bench for uart_decoder: serialises characters onto the line
// and compares decoded strobes against an event-level reference model.
`timescale 1ns/1ps
module tb_uart_decoder;

    localparam int unsigned BIT_CLKS = 12000000 / 115200;

    localparam logic [7:0] EV_DATA  = 8'd1;
    localparam logic [7:0] EV_START = 8'd2;
    localparam logic [7:0] EV_END   = 8'd3;
    localparam logic [7:0] EV_VSYNC = 8'd4;
    localparam logic [7:0] EV_INTR  = 8'd5;
    localparam logic [7:0] EV_ERROR = 8'd6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    uart_decoder_if bus();

    uart_decoder #(
        .CLOCK_FREQ (12000000),
        .BOUD_RATE  (115200)
    ) dut (
        .i_master_clk (clk),
        .i_reset_n    (rst_n),
        .i_uart_rx    (rx),
        .bus          (bus)
    );

    int n_checks;
    int n_errors;
    int cyc;
    int onehot_viol;
    int last_valid_cyc;
    int stop_start_cyc;

    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    bit         m_pending;
    logic [3:0] m_high;
    logic [7:0] m_last_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every strobe as an {event, data} word
    always @(negedge clk) begin : mon
        int n;
        n = int'(bus.o_rx_data_valid) + int'(bus.o_rx_start) + int'(bus.o_rx_end)
          + int'(bus.o_rx_vsync) + int'(bus.o_rx_interrupt) + int'(bus.o_rx_error);
        if (n > 1) onehot_viol++;
        if (rst_n) begin
            if (bus.o_rx_data_valid) begin
                obs_q.push_back({EV_DATA, bus.o_rx_data});
                last_valid_cyc = cyc;
            end
            if (bus.o_rx_start)     obs_q.push_back({EV_START, 8'h00});
            if (bus.o_rx_end)       obs_q.push_back({EV_END,   8'h00});
            if (bus.o_rx_vsync)     obs_q.push_back({EV_VSYNC, 8'h00});
            if (bus.o_rx_interrupt) obs_q.push_back({EV_INTR,  8'h00});
            if (bus.o_rx_error)     obs_q.push_back({EV_ERROR, 8'h00});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_hex(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit is_known(input logic [7:0] c);
        return (ref_hex(c) >= 0) || c == ":" || c == ";" || c == "#" || c == "^"
            || c == 8'h0D || c == 8'h0A;
    endfunction

    // Reference: what the consumer should see for one received character
    task automatic model_char(input logic [7:0] c, input bit stop_ok);
        int h;
        h = ref_hex(c);
        if (!stop_ok) begin
            exp_q.push_back({EV_ERROR, 8'h00});
            m_pending = 1'b0;
        end else if (c == ":") begin exp_q.push_back({EV_START, 8'h00}); m_pending = 1'b0; end
        else if (c == ";") begin exp_q.push_back({EV_END,   8'h00}); m_pending = 1'b0; end
        else if (c == "#") begin exp_q.push_back({EV_VSYNC, 8'h00}); m_pending = 1'b0; end
        else if (c == "^") begin exp_q.push_back({EV_INTR,  8'h00}); m_pending = 1'b0; end
        else if (c == 8'h0D || c == 8'h0A) begin end
        else if (h < 0) begin
            exp_q.push_back({EV_ERROR, 8'h00});
            m_pending = 1'b0;
        end else if (!m_pending) begin
            m_high    = 4'(h);
            m_pending = 1'b1;
        end else begin
            m_last_data = {m_high, 4'(h)};
            exp_q.push_back({EV_DATA, m_last_data});
            m_pending = 1'b0;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c, input bit stop_ok);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = c[i];
            wait_clks(BIT_CLKS);
        end
        stop_start_cyc = cyc;
        rx = stop_ok;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        if (!stop_ok) wait_clks(BIT_CLKS);
        model_char(c, stop_ok);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    task automatic compare_events(input string tag);
        int n;
        wait_clks(2 * BIT_CLKS);
        check_eq($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {24'h0, bus.o_rx_data_valid, bus.o_rx_start, bus.o_rx_end,
                       bus.o_rx_vsync, bus.o_rx_interrupt, bus.o_rx_error, 2'b00}, 32'h0);
        check_eq({tag, "_data"}, 32'(bus.o_rx_data), 32'h0);
    endtask

    initial begin
        int d;
        int cls;
        logic [7:0] c;
        string hexset;
        string symset;
        hexset = "0123456789ABCDEFabcdef";
        symset = ":;#^";
        m_pending   = 1'b0;
        m_high      = 4'h0;
        m_last_data = 8'h00;

        rst_n = 1'b0;
        wait_clks(5);
        check_quiet("reset");
        rst_n = 1'b1;
        wait_clks(10);

        // Framed byte, with latency of the data strobe after the low digit
        send_char(":", 1'b1);
        send_char("3", 1'b1);
        send_char("c", 1'b1);
        d = last_valid_cyc - stop_start_cyc;
        send_char(";", 1'b1);
        compare_events("frame");
        check_eq("latency", 32'(d), 32'd56);

        send_str("#^A5\r\n0F");
        compare_events("sym_crlf");

        send_str("7:12");
        compare_events("orphan");

        send_str("4G55");
        compare_events("illegal");

        send_char("1", 1'b0);
        send_str("22");
        compare_events("framing");

        // 0.3-bit low glitch on an idle line
        rx = 1'b0;
        wait_clks(BIT_CLKS * 3 / 10);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        compare_events("glitch");

        // Reset in the middle of data bit 4 of 'B', with a digit pending
        send_char("5", 1'b1);
        c = "B";
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = c[i];
            wait_clks(BIT_CLKS);
        end
        rx = c[4];
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        wait_clks(2);
        check_quiet("in_reset");
        wait_clks(10);
        check_quiet("in_reset_late");
        rx = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        m_pending   = 1'b0;
        m_last_data = 8'h00;
        obs_q.delete();
        exp_q.delete();
        wait_clks(20);
        send_str("9D");
        compare_events("after_reset");

        // Randomised character stream
        for (int k = 0; k < 24; k++) begin
            cls = int'($urandom_range(0, 9));
            if (cls <= 4 || cls == 9) begin
                c = hexset[int'($urandom_range(0, 21))];
                send_char(c, 1'b1);
            end else if (cls == 5) begin
                c = symset[int'($urandom_range(0, 3))];
                send_char(c, 1'b1);
            end else if (cls == 6) begin
                send_char(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, 1'b1);
            end else if (cls == 7) begin
                do c = 8'($urandom_range(0, 255)); while (is_known(c));
                send_char(c, 1'b1);
            end else begin
                c = hexset[int'($urandom_range(0, 21))];
                send_char(c, 1'b0);
            end
            wait_clks(int'($urandom_range(0, 30)));
        end
        compare_events("random");
        check_eq("data_hold", 32'(bus.o_rx_data), 32'(m_last_data));
        check_eq("onehot", 32'(onehot_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
